// File: rtl/dcache_port_arbiter.sv
// Shares the single D-cache port between load misses and store-buffer drains.
// state: IDLE | arbitrate, LOAD | load miss in flight, DRAIN | store-buffer head being written
module dcache_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ld_req,
    input  logic [ADDR_W-1:0] i_ld_addr,
    input  logic              i_sb_valid,
    input  logic              i_sb_full,
    input  logic [ADDR_W-1:0] i_sb_addr,
    input  logic [DATA_W-1:0] i_sb_data,
    input  logic              i_sb_byte,
    input  logic              i_flush_req,
    input  logic              i_cache_done,
    input  logic [DATA_W-1:0] i_cache_rdata,
    output logic              o_cache_req,
    output logic              o_cache_we,
    output logic [ADDR_W-1:0] o_cache_addr,
    output logic [DATA_W-1:0] o_cache_wdata,
    output logic              o_cache_byte,
    output logic              o_ld_done,
    output logic [DATA_W-1:0] o_ld_rdata,
    output logic              o_sb_pop,
    output logic              o_flush_done,
    output logic              o_pipe_stall
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_grant_ld;
    logic               w_grant_dr;
    logic               w_mask;
    logic               w_ld_fin;
    logic               w_dr_fin;
    logic               w_flush_clr;

    logic [CNT_W-1:0]   r_starve_cnt;
    logic               r_flush_pend;
    logic               r_we;
    logic               r_byte;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_ld_done;
    logic [DATA_W-1:0]  r_ld_rdata;
    logic               r_sb_pop;

    // The completion pulse cycle is dead time: the store buffer has not yet
    // retired the popped head, so granting here would re-drain stale data.
    assign w_mask      = r_sb_pop | r_ld_done;
    assign w_ld_fin    = (r_state == S_LOAD)  & i_cache_done;
    assign w_dr_fin    = (r_state == S_DRAIN) & i_cache_done;
    assign w_flush_clr = (r_state == S_IDLE) & r_flush_pend & ~i_sb_valid & ~r_sb_pop;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_ld  = 1'b0;
        w_grant_dr  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_mask) begin
                    if (r_flush_pend && i_sb_valid)                   w_grant_dr = 1'b1;
                    else if (i_sb_full)                               w_grant_dr = 1'b1;
                    else if (i_sb_valid && r_starve_cnt == CNT_MAX)   w_grant_dr = 1'b1;
                    else if (i_ld_req && !r_flush_pend)               w_grant_ld = 1'b1;
                    else if (i_sb_valid)                              w_grant_dr = 1'b1;
                end
                if (w_grant_ld) w_state_nxt = S_LOAD;
                if (w_grant_dr) w_state_nxt = S_DRAIN;
            end
            S_LOAD:  if (i_cache_done) w_state_nxt = S_IDLE;
            S_DRAIN: if (i_cache_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_ld_done  <= 1'b0;
            r_sb_pop   <= 1'b0;
            r_ld_rdata <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ld_done <= w_ld_fin;
            r_sb_pop  <= w_dr_fin;
            if (w_ld_fin) r_ld_rdata <= i_cache_rdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_we    <= 1'b0;
            r_byte  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_grant_ld) begin
            r_we    <= 1'b0;
            r_byte  <= 1'b0;
            r_addr  <= i_ld_addr;
            r_wdata <= '0;
        end else if (w_grant_dr) begin
            r_we    <= 1'b1;
            r_byte  <= i_sb_byte;
            r_addr  <= i_sb_addr;
            r_wdata <= i_sb_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_starve_cnt <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            if (!i_sb_valid || w_grant_dr)
                r_starve_cnt <= '0;
            else if (w_grant_ld && r_starve_cnt != CNT_MAX)
                r_starve_cnt <= r_starve_cnt + CNT_W'(1);

            // a request arriving in the completion cycle is already covered
            if (w_flush_clr)
                r_flush_pend <= 1'b0;
            else if (i_flush_req)
                r_flush_pend <= 1'b1;
        end
    end

    assign o_cache_req   = (r_state != S_IDLE);
    assign o_cache_we    = r_we;
    assign o_cache_addr  = r_addr;
    assign o_cache_wdata = r_wdata;
    assign o_cache_byte  = r_byte;
    assign o_ld_done     = r_ld_done;
    assign o_ld_rdata    = r_ld_rdata;
    assign o_sb_pop      = r_sb_pop;
    assign o_flush_done  = w_flush_clr;
    assign o_pipe_stall  = (i_ld_req & ~r_ld_done) | r_flush_pend;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter with a small store-buffer model that
// retires its head on the edge after sb_pop; expected values are hand-derived.
module tb_dcache_port_arbiter;

    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int SL       = 2;
    localparam int SB_DEPTH = 4;

    logic          clk = 1'b0;
    logic          i_rst, i_ld_req, i_sb_valid, i_sb_full, i_sb_byte;
    logic          i_flush_req, i_cache_done;
    logic [AW-1:0] i_ld_addr, i_sb_addr;
    logic [DW-1:0] i_sb_data, i_cache_rdata;
    logic          o_cache_req, o_cache_we, o_cache_byte, o_ld_done;
    logic          o_sb_pop, o_flush_done, o_pipe_stall;
    logic [AW-1:0] o_cache_addr;
    logic [DW-1:0] o_cache_wdata, o_ld_rdata;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [AW-1:0] sb_a [SB_DEPTH];
    logic [DW-1:0] sb_d [SB_DEPTH];
    logic          sb_b [SB_DEPTH];
    int            sb_n = 0;

    always #5 clk = ~clk;

    dcache_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_ld_req(i_ld_req), .i_ld_addr(i_ld_addr),
        .i_sb_valid(i_sb_valid), .i_sb_full(i_sb_full),
        .i_sb_addr(i_sb_addr), .i_sb_data(i_sb_data), .i_sb_byte(i_sb_byte),
        .i_flush_req(i_flush_req), .i_cache_done(i_cache_done), .i_cache_rdata(i_cache_rdata),
        .o_cache_req(o_cache_req), .o_cache_we(o_cache_we), .o_cache_addr(o_cache_addr),
        .o_cache_wdata(o_cache_wdata), .o_cache_byte(o_cache_byte),
        .o_ld_done(o_ld_done), .o_ld_rdata(o_ld_rdata), .o_sb_pop(o_sb_pop),
        .o_flush_done(o_flush_done), .o_pipe_stall(o_pipe_stall)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sb_drive();
        i_sb_valid = (sb_n > 0);
        i_sb_full  = (sb_n == SB_DEPTH);
        i_sb_addr  = (sb_n > 0) ? sb_a[0] : '0;
        i_sb_data  = (sb_n > 0) ? sb_d[0] : '0;
        i_sb_byte  = (sb_n > 0) ? sb_b[0] : 1'b0;
    endtask

    task automatic sb_push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic b);
        if (sb_n < SB_DEPTH) begin
            sb_a[sb_n] = a;
            sb_d[sb_n] = d;
            sb_b[sb_n] = b;
            sb_n++;
        end
        sb_drive();
    endtask

    // one clock: pulses (flush_req, cache_done) self-clear, store buffer pops
    task automatic cyc();
        logic pop;
        @(negedge clk);
        pop = o_sb_pop;
        @(posedge clk);
        #1;
        if (pop && sb_n > 0) begin
            for (int i = 0; i < SB_DEPTH - 1; i++) begin
                sb_a[i] = sb_a[i+1];
                sb_d[i] = sb_d[i+1];
                sb_b[i] = sb_b[i+1];
            end
            sb_n--;
        end
        sb_drive();
        i_flush_req  = 1'b0;
        i_cache_done = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        sb_n = 0;
        sb_drive();
        i_ld_req = 1'b0;
        i_ld_addr = '0;
        i_flush_req = 1'b0;
        i_cache_done = 1'b0;
        i_cache_rdata = '0;
        cyc();
        cyc();
        i_rst = 1'b0;
    endtask

    // entered in the first request cycle; leaves in the ld_done/sb_pop cycle
    task automatic run_txn(input int lat, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic byt,
                           input logic [DW-1:0] rdata, input string tag);
        check({tag, "_req"},   o_cache_req,   1);
        check({tag, "_we"},    o_cache_we,    we);
        check({tag, "_addr"},  o_cache_addr,  addr);
        check({tag, "_wdata"}, o_cache_wdata, wdata);
        check({tag, "_byte"},  o_cache_byte,  byt);
        for (int i = 1; i < lat; i++) begin
            cyc();
            check({tag, "_req_hold"},   o_cache_req,   1);
            check({tag, "_addr_hold"},  o_cache_addr,  addr);
            check({tag, "_wdata_hold"}, o_cache_wdata, wdata);
            check({tag, "_byte_hold"},  o_cache_byte,  byt);
        end
        i_cache_done  = 1'b1;
        i_cache_rdata = rdata;
        cyc();
        check({tag, "_req_end"}, o_cache_req, 0);
        check({tag, "_ld_done"}, o_ld_done,   !we);
        check({tag, "_sb_pop"},  o_sb_pop,    we);
        if (!we) check({tag, "_rdata"}, o_ld_rdata, rdata);
    endtask

    task automatic gap(input string tag);
        cyc();
        check({tag, "_gap_req"},  o_cache_req, 0);
        check({tag, "_gap_done"}, o_ld_done,   0);
        check({tag, "_gap_pop"},  o_sb_pop,    0);
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst = 1'b1;
        i_ld_req = 1'b0;
        i_ld_addr = '0;
        i_flush_req = 1'b0;
        i_cache_done = 1'b0;
        i_cache_rdata = '0;
        sb_drive();

        // reset state
        do_reset();
        check("rst_req",    o_cache_req,   0);
        check("rst_we",     o_cache_we,    0);
        check("rst_addr",   o_cache_addr,  0);
        check("rst_wdata",  o_cache_wdata, 0);
        check("rst_byte",   o_cache_byte,  0);
        check("rst_lddone", o_ld_done,     0);
        check("rst_rdata",  o_ld_rdata,    0);
        check("rst_pop",    o_sb_pop,      0);
        check("rst_fdone",  o_flush_done,  0);
        check("rst_stall",  o_pipe_stall,  0);

        // idle load, 3-cycle cache latency
        i_ld_req  = 1'b1;
        i_ld_addr = 32'h40;
        #1;
        check("ld_stall_pre", o_pipe_stall, 1);
        cyc();
        run_txn(3, 1'b0, 32'h40, 32'h0, 1'b0, 32'hDEADBEEF, "idle_ld");
        check("ld_stall_done", o_pipe_stall, 0);
        i_ld_req = 1'b0;
        cyc();
        check("ld_done_pulse", o_ld_done,  0);
        check("ld_rdata_keep", o_ld_rdata, 32'hDEADBEEF);
        check("ld_stall_post", o_pipe_stall, 0);

        // full buffer beats a waiting load
        do_reset();
        sb_push(32'hA0, 32'h1111_0000, 1'b0);
        sb_push(32'hA4, 32'h2222_0000, 1'b0);
        sb_push(32'hA8, 32'h3333_0000, 1'b1);
        sb_push(32'hAC, 32'h4444_0000, 1'b0);
        i_ld_req  = 1'b1;
        i_ld_addr = 32'h80;
        cyc();
        run_txn(1, 1'b1, 32'hA0, 32'h1111_0000, 1'b0, 32'h0, "full_dr");
        gap("full");
        run_txn(2, 1'b0, 32'h80, 32'h0, 1'b0, 32'h0000_1234, "full_ld");

        // starvation bound with STARVE_LIMIT = 2: L L D L L D
        do_reset();
        sb_push(32'hB0, 32'h0B0B_0000, 1'b0);
        sb_push(32'hB4, 32'h0B0B_0004, 1'b1);
        sb_push(32'hB8, 32'h0B0B_0008, 1'b0);
        i_ld_req  = 1'b1;
        i_ld_addr = 32'h100;
        cyc();
        run_txn(1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0000_0100, "stv_l1");
        i_ld_addr = 32'h104;
        gap("stv1");
        run_txn(1, 1'b0, 32'h104, 32'h0, 1'b0, 32'h0000_0104, "stv_l2");
        i_ld_addr = 32'h108;
        gap("stv2");
        run_txn(1, 1'b1, 32'hB0, 32'h0B0B_0000, 1'b0, 32'h0, "stv_d1");
        gap("stv3");
        run_txn(1, 1'b0, 32'h108, 32'h0, 1'b0, 32'h0000_0108, "stv_l3");
        i_ld_addr = 32'h10C;
        gap("stv4");
        run_txn(1, 1'b0, 32'h10C, 32'h0, 1'b0, 32'h0000_010C, "stv_l4");
        gap("stv5");
        run_txn(1, 1'b1, 32'hB4, 32'h0B0B_0004, 1'b1, 32'h0, "stv_d2");

        // flush of three entries while a load waits
        do_reset();
        sb_push(32'hC0, 32'hC0C0_0000, 1'b0);
        sb_push(32'hC4, 32'hC0C0_0004, 1'b0);
        sb_push(32'hC8, 32'hC0C0_0008, 1'b1);
        cyc();
        i_ld_req    = 1'b1;
        i_ld_addr   = 32'h200;
        i_flush_req = 1'b1;
        run_txn(2, 1'b1, 32'hC0, 32'hC0C0_0000, 1'b0, 32'h0, "fl_d0");
        check("fl_stall", o_pipe_stall, 1);
        gap("fl0");
        run_txn(1, 1'b1, 32'hC4, 32'hC0C0_0004, 1'b0, 32'h0, "fl_d1");
        gap("fl1");
        run_txn(1, 1'b1, 32'hC8, 32'hC0C0_0008, 1'b1, 32'h0, "fl_d2");
        check("fl_fdone_pop", o_flush_done, 0);
        cyc();
        check("fl_fdone",     o_flush_done, 1);
        check("fl_req_fdone", o_cache_req,  0);
        check("fl_stall_fd",  o_pipe_stall, 1);
        cyc();
        check("fl_fdone_end", o_flush_done, 0);
        check("fl_no_ld_yet", o_cache_req,  0);
        check("fl_stall_ld",  o_pipe_stall, 1);
        cyc();
        run_txn(1, 1'b0, 32'h200, 32'h0, 1'b0, 32'h0000_0200, "fl_ld");
        check("fl_stall_end", o_pipe_stall, 0);

        // reset beats flush_req; then flush of an empty buffer
        do_reset();
        i_rst       = 1'b1;
        i_flush_req = 1'b1;
        cyc();
        i_rst = 1'b0;
        cyc();
        check("rstfl_fdone", o_flush_done, 0);
        check("rstfl_stall", o_pipe_stall, 0);
        i_flush_req = 1'b1;
        cyc();
        check("fe_fdone",    o_flush_done, 1);
        check("fe_stall",    o_pipe_stall, 1);
        cyc();
        check("fe_fdone_end", o_flush_done, 0);
        check("fe_stall_end", o_pipe_stall, 0);

        // reset in the middle of a drain
        do_reset();
        sb_push(32'h300, 32'h55, 1'b0);
        cyc();
        check("rmd_req_pre", o_cache_req, 1);
        check("rmd_we_pre",  o_cache_we,  1);
        i_rst = 1'b1;
        sb_n = 0;
        sb_drive();
        cyc();
        check("rmd_req",   o_cache_req,   0);
        check("rmd_we",    o_cache_we,    0);
        check("rmd_addr",  o_cache_addr,  0);
        check("rmd_wdata", o_cache_wdata, 0);
        check("rmd_pop",   o_sb_pop,      0);
        check("rmd_fdone", o_flush_done,  0);
        i_rst        = 1'b0;
        i_cache_done = 1'b1;
        cyc();
        check("rmd_late_req",  o_cache_req, 0);
        check("rmd_late_pop",  o_sb_pop,    0);
        check("rmd_late_done", o_ld_done,   0);
        cyc();
        check("rmd_late_pop2", o_sb_pop,    0);

        // byte store drain held across a 3-cycle transaction
        do_reset();
        sb_push(32'h13, 32'hAB, 1'b1);
        cyc();
        run_txn(3, 1'b1, 32'h13, 32'hAB, 1'b1, 32'h0, "byte_dr");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
